pattern_src: RTL and testbench
==============================

# pattern_src

Synthesizable, parametrised successor to the bench-side stimulus source in this codebase: generates a stream of DATA_W-bit words on `Data`, advancing one word per rising edge of the consumer's `ack`. Adds selectable pattern modes, a programmable word count (or continuous run), start/stop control, and valid/busy/done status. Sits in front of the serial transmitter as its parallel data supplier, in both simulation and hardware.

## Interface
- DATA_W, 4, word width (4..16)
- COUNT_W, 8, width of word-count and sent-count
- START_VAL, 0, first word for increment/decrement modes
- SEED, 1, first LFSR word; a value of 0 is replaced by 1
- sclk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a run, honoured only in IDLE
- stop  in  1  terminate a run; honoured in SEND
- mode  in  2  0 increment, 1 decrement, 2 LFSR, 3 walking-one; latched at start
- count  in  COUNT_W  words per run, 0 = continuous; latched at start
- ack  in  1  consumer acknowledge, synchronous to sclk, edge-detected
- Data  out  DATA_W  current word
- valid  out  1  Data holds an unacknowledged word
- busy  out  1  run in progress (SEND state)
- done  out  1  one-cycle pulse at run end
- sent_cnt  out  COUNT_W  words acknowledged in the current or last run

## Operation
- States: IDLE, SEND, DONE.
- IDLE: `start & ~stop` latches mode/count, loads first word, goes to SEND. `start & stop` stays in IDLE. sent_cnt cleared on accepted start.
- First word: inc/dec = START_VAL; LFSR = SEED (0 → 1); walking-one = 1.
- ack edge = `ack & ~ack_q`, with ack_q registered every cycle in every state. Held-high ack counts once.
- SEND, ack edge: sent_cnt+1; Data advances to the next pattern value. If count≠0 and sent_cnt+1 == count, go to DONE instead.
- SEND, stop: go to DONE. If stop and an ack edge arrive in the same cycle, the ack counts, then the run ends.
- DONE: valid=0, busy=0, done=1 for one cycle, then IDLE. Data and sent_cnt hold.
- Next-value rules, modulo 2^DATA_W:
  - increment: +1, wraps max→0.
  - decrement: −1, wraps 0→max.
  - LFSR: Galois right-shift, next = (s>>1) ^ (s[0] ? TAPS : 0), maximal-length taps per width (4-bit TAPS = 4'hC). Never reaches 0.
  - walking-one: rotate left, MSB→bit0.
- Continuous mode (count=0): sent_cnt wraps silently; only stop ends the run.
- ack edges in IDLE/DONE are ignored.

## Timing
- Reset values: Data=0, valid=0, busy=0, done=0, sent_cnt=0, state IDLE, ack_q=0. Outputs clear immediately on rst assertion, without waiting for a clock edge. Reset mid-run aborts the run with no done pulse.
- start sampled at edge N → valid, busy and first word visible after edge N.
- ack rises before edge M → next word and sent_cnt update after edge M. Minimum one word per 2 cycles (ack must fall between words).
- Last ack at edge M → valid=0, busy=0, done=1 after M; done=0 after M+1. A new start is accepted from edge M+2.
- stop at edge S → valid=0, done=1 after S.

## Structure
- pattern_src_pkg:
  - state enum (IDLE/SEND/DONE) and mode enum (MODE_INC/DEC/LFSR/WALK).
  - function returning maximal-length LFSR taps for widths 4..16.
- One combinational sub-module, pattern_next: inputs mode and current word, output next word. pattern_src holds the FSM, edge detector, counters and output registers.

## Test plan
- DATA_W=4, START_VAL=0, mode 0, count 3: Data 0 → 1 → 2 on ack edges; third ack gives done pulse, valid=0, sent_cnt=3, Data holds 2.
- START_VAL=14, mode 0, count 4: Data 14, 15, 0, 1, then done. Mode 1 from START_VAL=1: 1, 0, 15.
- Mode 2, SEED=1, count 15: Data 1, C, 6, 3, D, …; 15 distinct non-zero words; a 16th run-word would be 1. SEED=0 starts at 1.
- ack held high 5 cycles in SEND: exactly one advance, sent_cnt=1. Mode 3: 1, 2, 4, 8, 1.
- count=0, 6 acks, then stop: run continues past 6 words until stop; done after stop edge; sent_cnt=6. start+stop together in IDLE → no run.
- rst raised mid-SEND between clock edges: Data, valid, busy and sent_cnt read 0 before the next sclk edge; no done pulse; after rst drops, a new start works normally.

Source files
------------

// File: rtl/pattern_src_pkg.sv
// Shared types and constants for the pattern source block.
package pattern_src_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_WALK = 2'd3
  } mode_t;

  // Galois right-shift tap masks for maximal-length sequences, widths 4..16.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h000C;
    endcase
  endfunction

endpackage

// File: rtl/pattern_next.sv
// Combinational next-word generator for all pattern modes.
module pattern_next
  import pattern_src_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  mode_t             mode,
  input  logic [DATA_W-1:0] cur,
  output logic [DATA_W-1:0] nxt
);

  localparam logic [15:0]       TAPS16 = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS   = TAPS16[DATA_W-1:0];

  // Pick the successor of the current word; all arithmetic wraps mod 2^DATA_W.
  always_comb begin
    nxt = cur;
    case (mode)
      MODE_INC:  nxt = cur + DATA_W'(1);
      MODE_DEC:  nxt = cur - DATA_W'(1);
      MODE_LFSR: nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);
      MODE_WALK: nxt = {cur[DATA_W-2:0], cur[DATA_W-1]};
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/pattern_src.sv
// Parallel word source: emits a patterned stream, one word per ack rising edge.
module pattern_src
  import pattern_src_pkg::*;
#(
  parameter int          DATA_W    = 4,
  parameter int          COUNT_W   = 8,
  parameter int unsigned START_VAL = 0,
  parameter int unsigned SEED      = 1
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] count,
  input  logic               ack,
  output logic [DATA_W-1:0]  Data,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sent_cnt
);

  localparam logic [DATA_W-1:0] START_W = DATA_W'(START_VAL);
  // An all-zero LFSR state would lock up, so a zero seed becomes 1.
  localparam logic [DATA_W-1:0] SEED_W  =
    (DATA_W'(SEED) == '0) ? DATA_W'(1) : DATA_W'(SEED);

  state_t              state, state_nxt;
  mode_t               mode_q;
  logic [COUNT_W-1:0]  count_q;
  logic                ack_q;
  logic                ack_edge, accept, last;
  logic [DATA_W-1:0]   first_word, next_word;

  assign ack_edge = ack & ~ack_q;
  assign accept   = (state == IDLE) & start & ~stop;
  assign last     = (count_q != '0) && ((sent_cnt + COUNT_W'(1)) == count_q);

  pattern_next #(.DATA_W(DATA_W)) u_next (
    .mode (mode_q),
    .cur  (Data),
    .nxt  (next_word)
  );

  // First word of a run is chosen from the unlatched mode input.
  always_comb begin
    first_word = START_W;
    case (mode_t'(mode))
      MODE_LFSR: first_word = SEED_W;
      MODE_WALK: first_word = DATA_W'(1);
      default:   first_word = START_W;
    endcase
  end

  // State register.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = SEND;
      SEND: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (stop || (ack_edge && last)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ack history for edge detection, tracked in every state.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= ack;
  end

  // Run setup and per-ack datapath; the word only advances if the run goes on.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      Data     <= '0;
      sent_cnt <= '0;
      mode_q   <= MODE_INC;
      count_q  <= '0;
    end else if (accept) begin
      mode_q   <= mode_t'(mode);
      count_q  <= count;
      Data     <= first_word;
      sent_cnt <= '0;
    end else if (state == SEND && ack_edge) begin
      sent_cnt <= sent_cnt + COUNT_W'(1);
      if (!last && !stop) Data <= next_word;
    end
  end

endmodule

// File: tb/tb_pattern_src.sv
// Scoreboard bench for pattern_src: three instances with different start/seed values.
module tb_pattern_src;

  localparam int DW = 4;
  localparam int CW = 8;

  logic          sclk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, stop = 1'b0, ack = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CW-1:0] count = '0;

  logic [DW-1:0] data  [3];
  logic          valid [3];
  logic          busy  [3];
  logic          done  [3];
  logic [CW-1:0] sent  [3];

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  always #5 sclk = ~sclk;

  pattern_src #(.DATA_W(DW), .COUNT_W(CW), .START_VAL(0), .SEED(1)) u0 (
    .sclk(sclk), .rst(rst), .start(start), .stop(stop), .mode(mode), .count(count),
    .ack(ack), .Data(data[0]), .valid(valid[0]), .busy(busy[0]), .done(done[0]),
    .sent_cnt(sent[0]));

  pattern_src #(.DATA_W(DW), .COUNT_W(CW), .START_VAL(14), .SEED(0)) u1 (
    .sclk(sclk), .rst(rst), .start(start), .stop(stop), .mode(mode), .count(count),
    .ack(ack), .Data(data[1]), .valid(valid[1]), .busy(busy[1]), .done(done[1]),
    .sent_cnt(sent[1]));

  pattern_src #(.DATA_W(DW), .COUNT_W(CW), .START_VAL(1), .SEED(1)) u2 (
    .sclk(sclk), .rst(rst), .start(start), .stop(stop), .mode(mode), .count(count),
    .ack(ack), .Data(data[2]), .valid(valid[2]), .busy(busy[2]), .done(done[2]),
    .sent_cnt(sent[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  // Reference successor written straight from the pattern definitions.
  function automatic logic [DW-1:0] model_next(input logic [1:0] m, input logic [DW-1:0] v);
    case (m)
      2'd0:    return v + 4'd1;
      2'd1:    return v - 4'd1;
      2'd2:    return {1'b0, v[3:1]} ^ (v[0] ? 4'hC : 4'h0);
      default: return {v[2:0], v[3]};
    endcase
  endfunction

  task automatic begin_run(input int u, input logic [1:0] m, input int n, input int nwords,
                           input logic [DW-1:0] fw);
    logic [DW-1:0] w;
    mode = m; count = CW'(n); start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_valid", valid[u], 1);
    chk("start_busy", busy[u], 1);
    chk("start_sent", sent[u], 0);
    exp_q.delete();
    w = fw;
    for (int i = 0; i < nwords; i++) begin
      exp_q.push_back(w);
      w = model_next(m, w);
    end
  endtask

  task automatic pop_check(input int u, output logic [DW-1:0] e);
    e = 'x;
    if (exp_q.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = exp_q.pop_front();
      chk("data", data[u], e);
    end
  endtask

  task automatic ack_word(input int u, input int hold);
    logic [DW-1:0] e;
    pop_check(u, e);
    ack = 1'b1;
    repeat (hold) tick;
    ack = 1'b0;
    tick;
  endtask

  task automatic last_ack(input int u, input int n);
    logic [DW-1:0] e;
    pop_check(u, e);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk("end_done", done[u], 1);
    chk("end_valid", valid[u], 0);
    chk("end_busy", busy[u], 0);
    chk("end_sent", sent[u], n);
    chk("end_data_hold", data[u], e);
    tick;
    chk("done_pulse_end", done[u], 0);
    chk("idle_busy", busy[u], 0);
  endtask

  initial begin
    logic [15:0] seen;
    logic [DW-1:0] lfsr_ref [5];
    lfsr_ref = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD};

    // Reset state, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_data", data[0], 0);
    chk("rst_valid", valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_sent", sent[0], 0);
    tick; tick;
    #2 rst = 1'b0;
    tick;

    // Increment, count 3: 0,1,2.
    begin_run(0, 2'd0, 3, 3, 4'd0);
    ack_word(0, 1);
    ack_word(0, 1);
    last_ack(0, 3);

    // Ack edges outside SEND are ignored.
    ack = 1'b1; tick; ack = 1'b0; tick;
    chk("idle_ack_sent", sent[0], 3);
    chk("idle_ack_busy", busy[0], 0);

    // Increment wrap from 14, count 4.
    begin_run(1, 2'd0, 4, 4, 4'd14);
    chk("inc_first14", data[1], 14);
    ack_word(1, 1);
    ack_word(1, 1);
    ack_word(1, 1);
    last_ack(1, 4);

    // Decrement wrap from 1: 1,0,15.
    begin_run(2, 2'd1, 3, 3, 4'd1);
    ack_word(2, 1);
    ack_word(2, 1);
    chk("dec_wrap", data[2], 4'hF);
    last_ack(2, 3);

    // LFSR, count 15 on seed 1; the zero-seed instance must also start at 1.
    begin_run(0, 2'd2, 15, 15, 4'd1);
    chk("seed0_first", data[1], 1);
    seen = '0;
    for (int i = 0; i < 14; i++) begin
      if (i < 5) chk("lfsr_prefix", data[0], lfsr_ref[i]);
      seen[data[0]] = 1'b1;
      ack_word(0, 1);
    end
    seen[data[0]] = 1'b1;
    last_ack(0, 15);
    chk("lfsr_distinct", seen, 16'hFFFE);
    chk("lfsr_last", data[0], 4'h2);

    // Walking-one, continuous; first ack held 5 cycles counts once.
    begin_run(0, 2'd3, 0, 6, 4'd1);
    ack_word(0, 5);
    chk("held_ack_sent", sent[0], 1);
    chk("held_ack_data", data[0], 2);
    for (int i = 0; i < 5; i++) ack_word(0, 1);
    chk("cont_busy", busy[0], 1);
    chk("cont_sent", sent[0], 6);
    chk("cont_data", data[0], 4);
    stop = 1'b1; tick; stop = 1'b0;
    chk("stop_done", done[0], 1);
    chk("stop_valid", valid[0], 0);
    chk("stop_sent", sent[0], 6);
    tick;
    chk("stop_done_end", done[0], 0);

    // start and stop together in IDLE: no run.
    start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy[0], 0);
    chk("startstop_valid", valid[0], 0);
    tick;
    chk("startstop_done", done[0], 0);

    // Reset mid-run, asserted between clock edges.
    begin_run(0, 2'd0, 5, 5, 4'd0);
    ack_word(0, 1);
    ack_word(0, 1);
    #2 rst = 1'b1;
    #2;
    chk("arst_data", data[0], 0);
    chk("arst_valid", valid[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_sent", sent[0], 0);
    tick;
    chk("arst_no_done", done[0], 0);
    #2 rst = 1'b0;
    tick;
    chk("post_rst_done", done[0], 0);

    // Fresh run after reset.
    begin_run(0, 2'd0, 2, 2, 4'd0);
    ack_word(0, 1);
    last_ack(0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
